led_trail_pwm: RTL and testbench
================================

# led_trail_pwm

Downstream stage of the LED chaser: consumes the chaser's `WIDTH`-bit LED pattern and drives the physical LED pins through per-LED PWM. Each LED that is lit in the pattern runs at full brightness. When the pattern moves on, the LED fades out linearly, which leaves a "comet tail" behind the rotating light. All state is per-LED brightness registers plus two free-running counters, a PWM phase counter and a decay prescaler.

## Interface
- `WIDTH`, default 8: number of LEDs; must match the chaser's width; ≥2.
- `LEVEL_BITS`, default 4: brightness resolution; MAX = 2^LEVEL_BITS − 1 (15 by default); ≥2.
- `DECAY_TICKS`, default 16: clocks between successive one-step brightness decrements; ≥1.

- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `led_in`  in  WIDTH: pattern from the chaser; bit i = 1 means LED i is currently the lit position.
- `fade_en`  in  1: 1 = trails decay gradually; 0 = unlit LEDs go dark immediately (no trail).
- `pwm_out`  out  WIDTH: registered PWM drive to LED pins.
- `all_dark`  out  1: registered; 1 when every brightness level is 0.

## Operation
- State:
  - `level[i]`: LEVEL_BITS wide, one per LED.
  - `pwm_cnt`: LEVEL_BITS wide.
  - `decay_cnt`: wide enough for DECAY_TICKS−1, minimum 1 bit.
- `pwm_cnt` counts 0,1,…,MAX−1 and then wraps to 0. The PWM period is MAX clocks. It is free-running and is not gated by `fade_en` or `led_in`.
- `decay_cnt` counts 0…DECAY_TICKS−1 and then wraps to 0. The decay strobe is asserted in the cycle where `decay_cnt == DECAY_TICKS−1`. With DECAY_TICKS=1 the strobe is asserted every cycle.
- Per-LED level update, evaluated every clock in priority order:
  1. `led_in[i]=1` → `level[i] ← MAX`. This wins over decay and over `fade_en`.
  2. else `fade_en=0` → `level[i] ← 0`.
  3. else strobe and `level[i]>0` → `level[i] ← level[i]−1`.
  4. else hold.
- Arithmetic rules:
  - A level never wraps below 0; a level at 0 holds at 0 on a strobe.
  - A level never exceeds MAX.
- PWM output: `pwm_out[i] ← (level[i] > pwm_cnt)`, an unsigned compare of the registered values.
  - level MAX → constantly 1.
  - level 0 → constantly 0.
  - level L → high for exactly L of every MAX consecutive clocks.
- `all_dark ← (all level[i] == 0)`, computed from the registered levels.
- Several bits of `led_in` may be set at once. Each LED is handled independently; nothing assumes the input is one-hot.

## Timing
- Synchronous reset takes effect at any edge where `rst=1`, overriding all inputs. Reset values:
  - every `level` = 0, `pwm_cnt` = 0, `decay_cnt` = 0;
  - `pwm_out` = 0;
  - `all_dark` = 1.
- Reset mid-operation: at the next edge all trails vanish and both counters restart from 0. On the first edge after release, `pwm_out` = 0 and `all_dark` = 1.
- Latency from `led_in[i]` rising:
  - `level[i]` = MAX after edge N (the sampling edge);
  - `pwm_out[i]` = 1 after edge N+1;
  - `all_dark` = 0 after edge N+1.
- Latency from `fade_en` falling with `led_in[i]=0`: `level[i]` = 0 after edge N; `pwm_out[i]` = 0 after edge N+1.
- Decay from MAX to 0 takes exactly MAX strobes: at most MAX·DECAY_TICKS clocks, at least (MAX−1)·DECAY_TICKS+1 clocks, depending on the prescaler phase.
- An input change coinciding with a strobe follows the priority order above: lit beats decay; `fade_en=0` beats decay.

## Test plan
Defaults for all scenarios: WIDTH=8, LEVEL_BITS=4, DECAY_TICKS=16.

1. **Reset priority.** Hold `rst=1` for 3 clocks with `led_in=8'hFF`, `fade_en=1`.
   - During reset and on the first edge after release: `pwm_out=8'h00`, `all_dark=1`.
   - `pwm_out=8'hFF` from the second edge after release.
2. **Static full brightness.** Drive `led_in=8'h01`, `fade_en=1`, held.
   - `pwm_out[0]` is high every cycle from edge 2 onward.
   - `pwm_out[7:1]=0`; `all_dark=0`.
3. **Linear fade and duty.** Drive `led_in=8'h01` for 20 clocks, then `8'h00`.
   - Measure `pwm_out[0]` duty over each 15-clock window: it steps 15,14,…,1,0 high-cycles, one step per 16 clocks.
   - `pwm_out[0]` is 0 and `all_dark=1` within 241 clocks of the release.
4. **Trail disabled.** With `level[3]` at 9, set `fade_en=0`, `led_in=8'h10`.
   - `pwm_out[3]=0` after 2 edges and stays 0.
   - `pwm_out[4]=1` continuously.
5. **Chaser feed.** Apply a one-hot pattern rotating left every 4 clocks from `8'h01`, `fade_en=1`, for 200 clocks.
   - At any time the current bit is at MAX.
   - The previous bit is at level 14 or 15.
   - No level underflows or exceeds 15.
   - `all_dark` stays 0.
6. **Mid-fade reset and simultaneous events.** Pulse `rst` for 1 clock mid-fade.
   - All outputs go to 0 and `all_dark=1` on the following edge.
   - Next, raise `led_in[2]` in the same cycle as a decay strobe: `level[2]=15`, not 14.

Source files
------------

// File: rtl/led_trail_pwm.sv
// led_trail_pwm
//   Downstream stage of the LED chaser. Every LED that is lit in the incoming
//   pattern is driven at full brightness. Once the pattern moves on, that LED
//   fades out linearly, which leaves a comet tail behind the rotating light.
//
//   Ports
//     clk      : single clock, all logic on the rising edge
//     rst      : synchronous, active-high reset
//     led_in   : WIDTH-bit pattern from the chaser (bit i = LED i lit)
//     fade_en  : 1 = unlit LEDs decay gradually, 0 = unlit LEDs go dark at once
//     pwm_out  : registered per-LED PWM drive
//     all_dark : registered, 1 when every brightness level is 0
//
//   Contents
//     led_trail_cell : one LED's brightness register and PWM comparator
//     led_trail_pwm  : shared PWM phase counter, decay prescaler and an
//                      array of led_trail_cell instances

// ---------------------------------------------------------------------------
// led_trail_cell
//   Brightness state and PWM output for one LED.
//
//   Ports
//     clk, rst : clock and synchronous active-high reset
//     lit      : this LED is the lit position in the current pattern
//     fade_en  : allow a gradual trail; 0 clears the level at once
//     strobe   : one-cycle decay strobe from the shared prescaler
//     pwm_cnt  : shared PWM phase, 0..MAX-1
//     level    : registered brightness, 0..MAX
//     pwm      : registered PWM drive for this LED
// ---------------------------------------------------------------------------
module led_trail_cell #(
  parameter int LEVEL_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lit,
  input  logic                  fade_en,
  input  logic                  strobe,
  input  logic [LEVEL_BITS-1:0] pwm_cnt,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  pwm
);

  localparam logic [LEVEL_BITS-1:0] MAX = '1;

  logic [LEVEL_BITS-1:0] level_nxt;

  // Priority: lit beats everything, then the trail-disable, then decay.
  // Decay only ever subtracts from a non-zero level, so it cannot wrap.
  always_comb begin
    level_nxt = level;
    if (lit)
      level_nxt = MAX;
    else if (!fade_en)
      level_nxt = '0;
    else if (strobe && (level != '0))
      level_nxt = level - LEVEL_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      level <= level_nxt;
      // Compare registered level against the registered phase. With the
      // phase running 0..MAX-1, level L is high for exactly L of MAX clocks.
      pwm   <= (level > pwm_cnt);
    end
  end

endmodule

// ---------------------------------------------------------------------------
// led_trail_pwm (top)
// ---------------------------------------------------------------------------
module led_trail_pwm #(
  parameter int WIDTH       = 8,
  parameter int LEVEL_BITS  = 4,
  parameter int DECAY_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  input  logic             fade_en,
  output logic [WIDTH-1:0] pwm_out,
  output logic             all_dark
);

  // Prescaler width: enough for DECAY_TICKS-1, never less than one bit.
  localparam int DC_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

  localparam logic [DC_W-1:0]       DC_LAST  = DC_W'(DECAY_TICKS - 1);
  // Last PWM phase is MAX-1: all ones except the LSB.
  localparam logic [LEVEL_BITS-1:0] PWM_LAST = {{(LEVEL_BITS-1){1'b1}}, 1'b0};

  logic [LEVEL_BITS-1:0]            pwm_cnt;
  logic [DC_W-1:0]                  decay_cnt;
  logic                             strobe;
  logic [WIDTH-1:0][LEVEL_BITS-1:0] levels;

  // PWM phase: 0..MAX-1, free-running, period MAX clocks.
  always_ff @(posedge clk) begin
    if (rst)
      pwm_cnt <= '0;
    else if (pwm_cnt == PWM_LAST)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + LEVEL_BITS'(1);
  end

  // Decay prescaler: strobe on the last count. With DECAY_TICKS=1 the
  // counter sits at 0 == DC_LAST, so the strobe is asserted every cycle.
  assign strobe = (decay_cnt == DC_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      decay_cnt <= '0;
    else if (strobe)
      decay_cnt <= '0;
    else
      decay_cnt <= decay_cnt + DC_W'(1);
  end

  // One cell per LED; each handled independently, input need not be one-hot.
  for (genvar i = 0; i < WIDTH; i++) begin : g_led
    led_trail_cell #(
      .LEVEL_BITS (LEVEL_BITS)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .lit     (led_in[i]),
      .fade_en (fade_en),
      .strobe  (strobe),
      .pwm_cnt (pwm_cnt),
      .level   (levels[i]),
      .pwm     (pwm_out[i])
    );
  end

  // Derived from the registered levels, so it trails them by one edge.
  always_ff @(posedge clk) begin
    if (rst)
      all_dark <= 1'b1;
    else
      all_dark <= (levels == '0);
  end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Scoreboard bench for led_trail_pwm. The driver applies inputs, advances a
// behavioural model (integer brightness per LED, integer phase and prescaler)
// at each edge and queues the outputs the DUT must show after that edge. A
// separate monitor pops one entry per cycle and compares.
module tb_led_trail_pwm;

  localparam int W   = 8;
  localparam int LB  = 4;
  localparam int DT  = 16;
  localparam int MAX = (1 << LB) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] led_in;
  logic         fade_en;
  logic [W-1:0] pwm_out;
  logic         all_dark;

  led_trail_pwm #(.WIDTH(W), .LEVEL_BITS(LB), .DECAY_TICKS(DT)) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .fade_en  (fade_en),
    .pwm_out  (pwm_out),
    .all_dark (all_dark)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_lvl [W];
  int m_ph;
  int m_dc;

  typedef struct packed {
    logic [W-1:0] pwm;
    logic         dark;
  } exp_t;

  exp_t exp_q[$];
  bit   started = 0;
  bit   done    = 0;

  // Apply inputs, take one edge, advance the model, queue the expectation.
  task automatic cyc(input logic r, input logic [W-1:0] led, input logic fe);
    exp_t e;
    bit   dark;
    rst = r; led_in = led; fade_en = fe;
    @(posedge clk);
    dark = 1;
    for (int i = 0; i < W; i++) begin
      e.pwm[i] = (m_lvl[i] > m_ph);
      if (m_lvl[i] != 0) dark = 0;
    end
    e.dark = dark;
    if (r) begin
      e.pwm = '0; e.dark = 1'b1;
      for (int i = 0; i < W; i++) m_lvl[i] = 0;
      m_ph = 0; m_dc = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (led[i])               m_lvl[i] = MAX;
        else if (!fe)             m_lvl[i] = 0;
        else if (m_dc == DT - 1)  m_lvl[i] = (m_lvl[i] > 0) ? m_lvl[i] - 1 : 0;
      end
      m_ph = (m_ph + 1) % MAX;
      m_dc = (m_dc + 1) % DT;
    end
    exp_q.push_back(e);
    started = 1;
    #1;
  endtask

  // Monitor: one output per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (started && !done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: no expectation queued for output pwm=%h dark=%b", pwm_out, all_dark);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== e.pwm || all_dark !== e.dark) begin
          errors++;
          $display("FAIL outputs @%0t: got pwm=%h dark=%b, expected pwm=%h dark=%b",
                   $time, pwm_out, all_dark, e.pwm, e.dark);
        end
      end
    end
  end

  // Directed check on the fade length: edges from release until all_dark.
  task automatic check_fade_len();
    int n;
    n = 0;
    while (n < 300) begin
      cyc(0, '0, 1);
      n++;
      if (all_dark === 1'b1) break;
    end
    checks++;
    if (n < 226 || n > 241) begin
      errors++;
      $display("FAIL fade_length: all_dark after %0d edges, required 226..241", n);
    end
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1; led_in = '0; fade_en = 1;
    for (int i = 0; i < W; i++) m_lvl[i] = 0;
    m_ph = 0; m_dc = 0;

    // 1. reset priority with all LEDs requested
    repeat (3) cyc(1, 8'hFF, 1);
    repeat (6) cyc(0, 8'hFF, 1);

    // 2. static full brightness on LED 0
    repeat (20) cyc(0, 8'h01, 1);

    // 3. linear fade from MAX after 20 lit clocks, with fade length check
    cyc(1, 8'h00, 1);
    repeat (20) cyc(0, 8'h01, 1);
    check_fade_len();
    repeat (5) cyc(0, 8'h00, 1);

    // 4. trail disabled while LED 3 is part-way down
    repeat (4) cyc(0, 8'h08, 1);
    while (m_lvl[3] > 9) cyc(0, 8'h00, 1);
    repeat (20) cyc(0, 8'h10, 0);

    // 5. chaser feed, one-hot rotating left every 4 clocks
    pat = 8'h01;
    for (int c = 0; c < 200; c++) begin
      cyc(0, pat, 1);
      if (c % 4 == 3) pat = {pat[W-2:0], pat[W-1]};
    end

    // 6. mid-fade reset, then led_in[2] rising on a decay strobe
    repeat (30) cyc(0, 8'h00, 1);
    cyc(1, 8'h00, 1);
    repeat (3) cyc(0, 8'h00, 1);
    repeat (4) cyc(0, 8'h04, 1);
    while (m_dc != DT - 1) cyc(0, 8'h00, 1);
    cyc(0, 8'h04, 1);
    repeat (30) cyc(0, 8'h00, 1);

    // random: sparse multi-hot patterns, fade_en toggles, rare resets
    for (int c = 0; c < 1500; c++) begin
      pat = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      cyc(($urandom_range(0, 199) == 0), pat, ($urandom_range(0, 19) != 0));
    end
    repeat (260) cyc(0, '0, 1);

    @(negedge clk);
    #1;
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
